instr_decode: RTL and testbench

- RV32I main decoder/control unit for the single-cycle-style core.
- Takes a 32-bit instruction word, produces datapath control strobes, the 2-bit ALU-op class for the downstream ALU-control block, and the sign-extended immediate.
- Outputs are registered: one pipeline stage between fetch and execute.

---
 rtl/rv32_pkg.sv | 35 +++
 rtl/imm_gen.sv | 35 +++
 rtl/instr_decode.sv | 162 ++++++++++++++++
 tb/tb_instr_decode.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I opcode, ALU-op and immediate-format definitions
//
// Purpose: common constants for the decoder and immediate generator.
// Contents: opcode localparams, 2-bit ALU-op class encodings,
//           immediate-format enum.
package rv32_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // IMM_NONE yields zero: used for R-type and unrecognised opcodes.
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate generator
//
// Purpose: builds the sign-extended immediate for the format chosen by
//          the decoder.
// Ports:
//   instr_hi   in  25  instruction bits [31:7] (opcode is not needed here)
//   fmt        in      immediate format select
//   immediate  out 32  sign-extended immediate
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:7] instr_hi,
  input  imm_fmt_e    fmt,
  output logic [31:0] immediate
);

  logic sign;

  assign sign = instr_hi[31];

  always_comb begin
    immediate = '0;
    unique case (fmt)
      IMM_I: immediate = {{20{sign}}, instr_hi[31:20]};
      IMM_S: immediate = {{20{sign}}, instr_hi[31:25], instr_hi[11:7]};
      IMM_B: immediate = {{19{sign}}, sign, instr_hi[7], instr_hi[30:25],
                          instr_hi[11:8], 1'b0};
      IMM_U: immediate = {instr_hi[31:12], 12'b0};
      IMM_J: immediate = {{11{sign}}, sign, instr_hi[19:12], instr_hi[20],
                          instr_hi[30:21], 1'b0};
      default: immediate = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - RV32I main decoder / control unit with registered outputs
//
// Purpose: decodes the opcode of a valid instruction into datapath control
//          strobes, the ALU-op class and the sign-extended immediate, all
//          registered one cycle after the instruction is presented.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid, instr instruction word and its qualifier
//   out_valid       registered outputs hold a decoded instruction
//   branch, jump, mem_read, memtoreg, mem_write, alu_src, write_enable
//                   control strobes
//   alu_op          2-bit ALU-op class for the ALU-control block
//   illegal_instr   opcode not recognised
//   immediate       sign-extended immediate
module instr_decode
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] instr,
  output logic            out_valid,
  output logic            branch,
  output logic            jump,
  output logic            mem_read,
  output logic            memtoreg,
  output logic            mem_write,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic            write_enable,
  output logic            illegal_instr,
  output logic [XLEN-1:0] immediate
);

  logic [6:0]      opcode;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] imm_next;

  logic       branch_d;
  logic       jump_d;
  logic       mem_read_d;
  logic       memtoreg_d;
  logic       mem_write_d;
  logic       alu_src_d;
  logic [1:0] alu_op_d;
  logic       write_enable_d;
  logic       illegal_d;

  assign opcode = instr[6:0];

  // Control table; funct3/funct7 are left to the ALU-control block.
  always_comb begin
    branch_d       = 1'b0;
    jump_d         = 1'b0;
    mem_read_d     = 1'b0;
    memtoreg_d     = 1'b0;
    mem_write_d    = 1'b0;
    alu_src_d      = 1'b0;
    alu_op_d       = ALUOP_ADD;
    write_enable_d = 1'b0;
    illegal_d      = 1'b0;
    fmt            = IMM_NONE;
    case (opcode)
      OP_R: begin
        write_enable_d = 1'b1;
        alu_op_d       = ALUOP_R;
      end
      OP_IMM: begin
        alu_src_d      = 1'b1;
        write_enable_d = 1'b1;
        alu_op_d       = ALUOP_I;
        fmt            = IMM_I;
      end
      OP_LOAD: begin
        alu_src_d      = 1'b1;
        memtoreg_d     = 1'b1;
        mem_read_d     = 1'b1;
        write_enable_d = 1'b1;
        fmt            = IMM_I;
      end
      OP_STORE: begin
        alu_src_d   = 1'b1;
        mem_write_d = 1'b1;
        fmt         = IMM_S;
      end
      OP_BRANCH: begin
        branch_d = 1'b1;
        alu_op_d = ALUOP_BR;
        fmt      = IMM_B;
      end
      OP_JAL: begin
        jump_d         = 1'b1;
        write_enable_d = 1'b1;
        fmt            = IMM_J;
      end
      OP_JALR: begin
        jump_d         = 1'b1;
        alu_src_d      = 1'b1;
        write_enable_d = 1'b1;
        fmt            = IMM_I;
      end
      OP_LUI, OP_AUIPC: begin
        alu_src_d      = 1'b1;
        write_enable_d = 1'b1;
        fmt            = IMM_U;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  imm_gen u_imm_gen (
    .instr_hi  (instr[31:7]),
    .fmt       (fmt),
    .immediate (imm_next)
  );

  // An invalid cycle registers a bubble: every output returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      branch        <= 1'b0;
      jump          <= 1'b0;
      mem_read      <= 1'b0;
      memtoreg      <= 1'b0;
      mem_write     <= 1'b0;
      alu_src       <= 1'b0;
      alu_op        <= 2'b00;
      write_enable  <= 1'b0;
      illegal_instr <= 1'b0;
      immediate     <= '0;
    end else if (in_valid) begin
      out_valid     <= 1'b1;
      branch        <= branch_d;
      jump          <= jump_d;
      mem_read      <= mem_read_d;
      memtoreg      <= memtoreg_d;
      mem_write     <= mem_write_d;
      alu_src       <= alu_src_d;
      alu_op        <= alu_op_d;
      write_enable  <= write_enable_d;
      illegal_instr <= illegal_d;
      immediate     <= imm_next;
    end else begin
      out_valid     <= 1'b0;
      branch        <= 1'b0;
      jump          <= 1'b0;
      mem_read      <= 1'b0;
      memtoreg      <= 1'b0;
      mem_write     <= 1'b0;
      alu_src       <= 1'b0;
      alu_op        <= 2'b00;
      write_enable  <= 1'b0;
      illegal_instr <= 1'b0;
      immediate     <= '0;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// tb/tb_instr_decode.sv - scoreboard testbench for instr_decode
module tb_instr_decode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_valid;
  logic        branch;
  logic        jump;
  logic        mem_read;
  logic        memtoreg;
  logic        mem_write;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        write_enable;
  logic        illegal_instr;
  logic [31:0] immediate;

  int checks;
  int failures;
  bit done;

  typedef struct {
    string       name;
    logic [41:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];

  instr_decode #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .instr         (instr),
    .out_valid     (out_valid),
    .branch        (branch),
    .jump          (jump),
    .mem_read      (mem_read),
    .memtoreg      (memtoreg),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .alu_op        (alu_op),
    .write_enable  (write_enable),
    .illegal_instr (illegal_instr),
    .immediate     (immediate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {illegal, branch, jump, mem_read, memtoreg, mem_write, alu_src, alu_op, write_enable, immediate}
  function automatic logic [41:0] observed();
    return {illegal_instr, branch, jump, mem_read, memtoreg, mem_write,
            alu_src, alu_op, write_enable, immediate};
  endfunction

  task automatic check(input string name, input logic [42:0] got, input logic [42:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ctl = {illegal, branch, jump, mem_read, memtoreg, mem_write, alu_src, alu_op[1:0], write_enable}
  task automatic issue(input string name, input logic [31:0] ins,
                       input logic [9:0] ctl, input logic [31:0] imm);
    sb_entry_t e;
    @(negedge clk);
    in_valid = 1'b1;
    instr    = ins;
    e.name   = name;
    e.exp    = {ctl, imm};
    sb.push_back(e);
  endtask

  task automatic bubble();
    @(negedge clk);
    in_valid = 1'b0;
    instr    = 32'hDEAD_BEEF;
  endtask

  // Monitor: a valid output pops the scoreboard; an invalid one must be all zero.
  initial begin
    sb_entry_t e;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", {1'b1, observed()}, {1'b0, 42'h0});
        end else begin
          e = sb.pop_front();
          check(e.name, {1'b1, observed()}, {1'b1, e.exp});
        end
      end else begin
        check("bubble_zero", {out_valid, observed()}, 43'h0);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    done     = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = 32'h0;
    #3;
    check("reset_state", {out_valid, observed()}, 43'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //                            ill br jp mr m2 mw src op   we
    issue("r_type",  32'h002081B3, 10'b0_0_0_0_0_0_0_10_1, 32'h0000_0000);
    issue("load",    32'h0040A103, 10'b0_0_0_1_1_0_1_00_1, 32'h0000_0004);
    issue("store",   32'h00312223, 10'b0_0_0_0_0_1_1_00_0, 32'h0000_0004);
    issue("branch_pos", 32'h002081E3, 10'b0_1_0_0_0_0_0_01_0, 32'h0000_0802);
    issue("branch_neg", 32'h802081E3, 10'b0_1_0_0_0_0_0_01_0, 32'hFFFF_F802);
    issue("jal",     32'h0000106F, 10'b0_0_1_0_0_0_0_00_1, 32'h0000_1000);
    issue("jal_neg", 32'hFFDFF0EF, 10'b0_0_1_0_0_0_0_00_1, 32'hFFFF_FFFC);
    issue("addi_neg", 32'hFFF00093, 10'b0_0_0_0_0_0_1_11_1, 32'hFFFF_FFFF);
    issue("store_neg", 32'hFE112E23, 10'b0_0_0_0_0_1_1_00_0, 32'hFFFF_FFFC);
    issue("jalr_neg", 32'h800080E7, 10'b0_0_1_0_0_0_1_00_1, 32'hFFFF_F800);
    issue("lui",     32'h123450B7, 10'b0_0_0_0_0_0_1_00_1, 32'h1234_5000);
    issue("auipc",   32'h00001097, 10'b0_0_0_0_0_0_1_00_1, 32'h0000_1000);
    issue("fence_illegal", 32'h0000100F, 10'b1_0_0_0_0_0_0_00_0, 32'h0000_0000);
    issue("illegal", 32'h00001007, 10'b1_0_0_0_0_0_0_00_0, 32'h0000_0000);
    bubble();
    bubble();

    // Mid-stream asynchronous reset: outputs clear without a clock edge.
    issue("jal_pre_reset", 32'h0000106F, 10'b0_0_1_0_0_0_0_00_1, 32'h0000_1000);
    @(posedge clk);
    #2;
    check("valid_before_reset", {42'h0, out_valid}, {42'h0, 1'b1});
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", {out_valid, observed()}, 43'h0);
    void'(sb.pop_front());
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue("post_reset_load", 32'h0040A103, 10'b0_0_0_1_1_0_1_00_1, 32'h0000_0004);
    bubble();
    repeat (3) @(negedge clk);

    check("scoreboard_drained", {11'h0, sb.size()}, 43'h0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
